// File: rtl/mem_responder_if.sv
// Bus bundle between the address generation side (master) and mem_responder (slave).
interface mem_responder_if;
  logic        ale;
  logic [19:0] addr;
  logic        rd;
  logic        wr;
  logic        word;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (output ale, addr, rd, wr, word, wdata,
                  input  rdata, ready, busy, err);
  modport slave  (input  ale, addr, rd, wr, word, wdata,
                  output rdata, ready, busy, err);
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: byte/word access to a 16-bit RAM window with wait states.
// Macro MEM_RESP_UNALIGNED_EN enables odd-address word accesses split over XFER/XFER2.
module mem_responder #(
  parameter logic [19:0] MEM_BASE    = 20'h00000,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);
  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned SPAN  = 2 * MEM_WORDS;
  localparam int unsigned CNT_W = 4;
`ifdef MEM_RESP_UNALIGNED_EN
  localparam bit UNALIGNED = 1'b1;
`else
  localparam bit UNALIGNED = 1'b0;
`endif

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_XFER, ST_XFER2, ST_DONE} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [19:0]        addr_q;
  logic               rd_q, wr_q, word_q, acc_err_q;
  logic [15:0]        wdata_q, buf_q, rdata_q;
  logic               ready_q, busy_q, err_q;
  logic [15:0]        mem_q [MEM_WORDS];

  logic [19:0]        addr_nxt_d, off_c;
  logic [IDX_W-1:0]   idx_c;
  logic [15:0]        mem_word_c;
  logic               acc_err_c, split_c;
  logic [1:0]         wen_c;
  logic [15:0]        wval_c;

  // Byte offset from the window base, modulo 2^20; anything past SPAN is outside.
  function automatic logic in_window(input logic [19:0] a);
    logic [19:0] off;
    off = a - MEM_BASE;
    return 32'(off) < SPAN;
  endfunction

  assign addr_nxt_d = bus.addr + 20'd1;
  assign acc_err_c  = (bus.rd & bus.wr) | ~in_window(bus.addr)
                    | (bus.word & ~in_window(addr_nxt_d))
                    | (bus.word & bus.addr[0] & ~UNALIGNED);

  assign off_c      = addr_q - MEM_BASE;
  assign idx_c      = IDX_W'(off_c >> 1);
  assign mem_word_c = mem_q[idx_c];
  assign split_c    = UNALIGNED & word_q & addr_q[0];

  // Lane enables for the write committed at the end of XFER / XFER2.
  always_comb begin
    wen_c  = 2'b00;
    wval_c = 16'h0000;
    if (wr_q && !acc_err_q) begin
      if (state_q == ST_XFER) begin
        if (word_q && !addr_q[0]) begin
          wen_c  = 2'b11;
          wval_c = wdata_q;
        end else if (addr_q[0]) begin
          wen_c  = 2'b10;
          wval_c = {wdata_q[7:0], 8'h00};
        end else begin
          wen_c  = 2'b01;
          wval_c = {8'h00, wdata_q[7:0]};
        end
      end else if (state_q == ST_XFER2) begin
        wen_c  = 2'b01;
        wval_c = {8'h00, wdata_q[15:8]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wen_c[0]) mem_q[idx_c][7:0]  <= wval_c[7:0];
    if (wen_c[1]) mem_q[idx_c][15:8] <= wval_c[15:8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      word_q    <= 1'b0;
      acc_err_q <= 1'b0;
      wdata_q   <= '0;
      buf_q     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        // busy_q still set here means this is the ready cycle; ale is not taken until the next one.
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (!busy_q && bus.ale && (bus.rd | bus.wr)) begin
            addr_q    <= bus.addr;
            rd_q      <= bus.rd;
            wr_q      <= bus.wr;
            word_q    <= bus.word;
            wdata_q   <= bus.wdata;
            acc_err_q <= acc_err_c;
            busy_q    <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_q <= ST_XFER;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_W'(WAIT_STATES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) state_q <= ST_XFER;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        ST_XFER: begin
          if (word_q && !addr_q[0]) buf_q <= mem_word_c;
          else if (addr_q[0])       buf_q <= {8'h00, mem_word_c[15:8]};
          else                      buf_q <= {8'h00, mem_word_c[7:0]};
          if (split_c) begin
            addr_q  <= addr_q + 20'd1;
            state_q <= ST_XFER2;
          end else begin
            state_q <= ST_DONE;
          end
        end
        ST_XFER2: begin
          buf_q[15:8] <= mem_word_c[7:0];
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          ready_q <= 1'b1;
          err_q   <= acc_err_q;
          if (rd_q) rdata_q <= acc_err_q ? 16'hFFFF : buf_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: three responders with different windows/wait states share one bus stimulus.
module tb_mem_responder;
  localparam int NDUT = 3;
  localparam int unsigned BASE  [NDUT] = '{32'h00000, 32'hFFC00, 32'h00000};
  localparam int unsigned WORDS [NDUT] = '{1024, 512, 1024};
  localparam int unsigned WS    [NDUT] = '{1, 2, 0};
  localparam int unsigned REG   [4]    = '{32'h00000, 32'h003E0, 32'h007E0, 32'hFFFC0};
`ifdef MEM_RESP_UNALIGNED_EN
  localparam bit UNAL = 1'b1;
`else
  localparam bit UNAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ale = 1'b0;
  logic [19:0] addr = '0;
  logic        rd = 1'b0, wr = 1'b0, word = 1'b0;
  logic [15:0] wdata = '0;

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [int];

  always #5 clk = ~clk;

  mem_responder_if if0 ();
  mem_responder_if if1 ();
  mem_responder_if if2 ();

  assign if0.ale = ale;  assign if0.addr = addr;  assign if0.rd = rd;
  assign if0.wr = wr;    assign if0.word = word;  assign if0.wdata = wdata;
  assign if1.ale = ale;  assign if1.addr = addr;  assign if1.rd = rd;
  assign if1.wr = wr;    assign if1.word = word;  assign if1.wdata = wdata;
  assign if2.ale = ale;  assign if2.addr = addr;  assign if2.rd = rd;
  assign if2.wr = wr;    assign if2.word = word;  assign if2.wdata = wdata;

  mem_responder #(.MEM_BASE(20'h00000), .MEM_WORDS(1024), .WAIT_STATES(1))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mem_responder #(.MEM_BASE(20'hFFC00), .MEM_WORDS(512), .WAIT_STATES(2))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  mem_responder #(.MEM_BASE(20'h00000), .MEM_WORDS(1024), .WAIT_STATES(0))
    u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  // {ready, busy, err, rdata}
  function automatic logic [18:0] outs(input int d);
    case (d)
      0:       return {if0.ready, if0.busy, if0.err, if0.rdata};
      1:       return {if1.ready, if1.busy, if1.err, if1.rdata};
      default: return {if2.ready, if2.busy, if2.err, if2.rdata};
    endcase
  endfunction

  function automatic int mkey(input int d, input logic [19:0] a);
    return (d << 20) | int'({12'h000, a});
  endfunction

  function automatic bit in_win(input int d, input logic [19:0] a);
    int unsigned ai;
    ai = {12'h000, a};
    return (ai >= BASE[d]) && (ai < BASE[d] + 2 * WORDS[d]);
  endfunction

  function automatic bit acc_err(input int d, input logic [19:0] a, input logic r,
                                 input logic w, input logic wo);
    logic [19:0] a1;
    a1 = a + 20'd1;
    return (r && w) || !in_win(d, a) || (wo && !in_win(d, a1)) || (wo && a[0] && !UNAL);
  endfunction

  // Reference behaviour of one access: latency in edges, error flag, read data; updates memory.
  function automatic void model_access(input int d, input logic [19:0] a, input logic r,
                                       input logic w, input logic wo, input logic [15:0] wd,
                                       output int lat, output bit e, output logic [15:0] rv);
    logic [19:0] a1;
    a1  = a + 20'd1;
    e   = acc_err(d, a, r, w, wo);
    lat = int'(WS[d]) + 2 + ((wo && a[0] && UNAL) ? 1 : 0);
    rv  = 16'hFFFF;
    if (!e && w) begin
      mdl[mkey(d, a)] = wd[7:0];
      if (wo) mdl[mkey(d, a1)] = wd[15:8];
    end
    if (!e && r) rv = wo ? {mdl[mkey(d, a1)], mdl[mkey(d, a)]} : {8'h00, mdl[mkey(d, a)]};
  endfunction

  task automatic do_tx(input logic [19:0] a, input logic r, input logic w, input logic wo,
                       input logic [15:0] wd, input bit extra, input string tag);
    int lat [NDUT];
    bit ee [NDUT];
    logic [15:0] er [NDUT];
    int seen [NDUT];
    int pulses [NDUT];
    int maxlat;
    logic [18:0] o;
    maxlat = 0;
    for (int d = 0; d < NDUT; d++) begin
      model_access(d, a, r, w, wo, wd, lat[d], ee[d], er[d]);
      seen[d] = -1;
      pulses[d] = 0;
      if (lat[d] > maxlat) maxlat = lat[d];
    end
    @(negedge clk);
    addr = a; rd = r; wr = w; word = wo; wdata = wd; ale = 1'b1;
    @(posedge clk); #1;
    ale = extra;
    if (extra) begin
      addr = 20'h00004; rd = 1'b0; wr = 1'b1; word = 1'b1; wdata = 16'hDEAD;
    end
    for (int k = 1; k <= maxlat + 1; k++) begin
      @(posedge clk); #1;
      if (k == 1) ale = 1'b0;
      for (int d = 0; d < NDUT; d++) begin
        o = outs(d);
        if (k == 1) begin
          checks++;
          if (o[18:16] !== 3'b010) begin
            errors++;
            $display("FAIL %s dut%0d start ready/busy/err got %b want 010", tag, d, o[18:16]);
          end
        end
        if (o[18] === 1'b1) begin
          pulses[d]++;
          if (seen[d] < 0) begin
            seen[d] = k;
            checks++;
            if (o[16] !== ee[d]) begin
              errors++;
              $display("FAIL %s dut%0d err got %b want %b", tag, d, o[16], ee[d]);
            end
            if (r) begin
              checks++;
              if (o[15:0] !== er[d]) begin
                errors++;
                $display("FAIL %s dut%0d rdata got %h want %h", tag, d, o[15:0], er[d]);
              end
            end
          end
        end
        if (k == maxlat + 1) begin
          checks++;
          if (o[18:17] !== 2'b00) begin
            errors++;
            $display("FAIL %s dut%0d end ready/busy got %b want 00", tag, d, o[18:17]);
          end
        end
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (seen[d] != lat[d] || pulses[d] != 1) begin
        errors++;
        $display("FAIL %s dut%0d ready edge got %0d (pulses %0d) want %0d (pulses 1)",
                 tag, d, seen[d], pulses[d], lat[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (outs(d) !== 19'h0) begin
        errors++;
        $display("FAIL reset dut%0d outputs got %h want 00000", d, outs(d));
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic init_mem();
    for (int g = 0; g < 4; g++)
      for (int off = 0; off < 64; off += 2)
        do_tx(20'(REG[g] + off), 1'b0, 1'b1, 1'b1, 16'($urandom), 1'b0, "init");
  endtask

  task automatic test_word_rw();
    do_tx(20'h00010, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0, "word_wr");
    do_tx(20'h00010, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, "word_rd");
  endtask

  task automatic test_byte_merge();
    do_tx(20'h00011, 1'b0, 1'b1, 1'b0, 16'hA55A, 1'b0, "byte_wr");
    do_tx(20'h00010, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, "merge_rd");
  endtask

  task automatic test_split();
    do_tx(20'h00021, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, "split_wr");
    do_tx(20'h00021, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, "split_rd_lo");
    do_tx(20'h00022, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, "split_rd_hi");
    do_tx(20'h00021, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, "split_rd_word");
  endtask

  task automatic test_window();
    do_tx(20'h003FF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, "win_3ff");
    do_tx(20'hFFFFF, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, "win_wrap");
    do_tx(20'hFFFFE, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, "win_top");
    do_tx(20'h007FF, 1'b0, 1'b1, 1'b1, 16'h7788, 1'b0, "win_edge_wr");
    do_tx(20'h007FE, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, "win_edge_rd");
  endtask

  task automatic test_ale_during_wait();
    do_tx(20'h00030, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, "ale_in_wait");
    do_tx(20'h00004, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, "ale_no_side");
  endtask

  task automatic test_rd_wr_both();
    do_tx(20'h00008, 1'b1, 1'b1, 1'b1, 16'hCAFE, 1'b0, "rd_wr_both");
    do_tx(20'h00008, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, "rd_wr_check");
  endtask

  task automatic test_idle_ale();
    int hits [NDUT];
    for (int d = 0; d < NDUT; d++) hits[d] = 0;
    @(negedge clk);
    addr = 20'h00012; rd = 1'b0; wr = 1'b0; word = 1'b1; ale = 1'b1;
    @(negedge clk);
    ale = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < NDUT; d++) if (outs(d)[18:17] !== 2'b00) hits[d]++;
    end
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (hits[d] != 0) begin
        errors++;
        $display("FAIL idle_ale dut%0d active cycles got %0d want 0", d, hits[d]);
      end
    end
  endtask

  task automatic test_reset_split();
    logic [19:0] a;
    logic [15:0] wd;
    a  = 20'h00021;
    wd = 16'($urandom);
    @(negedge clk);
    addr = a; rd = 1'b0; wr = 1'b1; word = 1'b1; wdata = wd; ale = 1'b1;
    @(posedge clk); #1;
    ale = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (outs(d) !== 19'h0) begin
        errors++;
        $display("FAIL rst_split dut%0d outputs got %h want 00000", d, outs(d));
      end
      // Low byte commits at edge WS+1, high byte at WS+2; reset came after edge 2.
      if (UNAL && !acc_err(d, a, 1'b0, 1'b1, 1'b1)) begin
        if (WS[d] + 1 <= 2) mdl[mkey(d, a)] = wd[7:0];
        if (WS[d] + 2 <= 2) mdl[mkey(d, a + 20'd1)] = wd[15:8];
      end
    end
    @(negedge clk);
    rst = 1'b0;
    do_tx(a, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, "rst_split_lo");
    do_tx(a + 20'd1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, "rst_split_hi");
  endtask

  task automatic test_random();
    int g, off, op;
    logic wo;
    for (int n = 0; n < 150; n++) begin
      g   = $urandom_range(0, 3);
      wo  = 1'($urandom_range(0, 1));
      off = wo ? $urandom_range(0, 62) : $urandom_range(0, 63);
      op  = $urandom_range(0, 9);
      do_tx(20'(REG[g] + off), op == 0 || op >= 5, op <= 4, wo, 16'($urandom), 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_word_rw();
    test_byte_merge();
    test_split();
    test_window();
    test_ale_during_wait();
    test_rd_wr_both();
    test_idle_ale();
    test_reset_split();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the 20-bit physical bus driven by the address generation unit (physical address = segment·16 + offset). It accepts a one-cycle address strobe, then services a byte or word read/write against an internal 16-bit-wide RAM window with programmable wait states. Completion is signalled with a one-cycle `ready` pulse. It sits on the memory end of the bus interface, opposite the CPU's address path.

## Interface
- `MEM_BASE`, 20'h00000: first physical byte address of the RAM window (even).
- `MEM_WORDS`, 1024: window size in 16-bit words; the window spans bytes [MEM_BASE, MEM_BASE+2·MEM_WORDS).
- `WAIT_STATES`, 1: wait cycles inserted per access (0–15).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ale`  in  1  address latch enable; a one-cycle strobe that starts a bus cycle.
- `addr`  in  20  physical byte address, sampled with `ale`.
- `rd`  in  1  read request, sampled with `ale`.
- `wr`  in  1  write request, sampled with `ale`.
- `word`  in  1  1 = 16-bit access, 0 = byte access; sampled with `ale`.
- `wdata`  in  16  write data, sampled with `ale`; byte writes use [7:0].
- `rdata`  out  16  read data; valid while `ready` is high and held until the next `ready`.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from the cycle after `ale` is accepted until `ready` is high, inclusive.
- `err`  out  1  high only together with `ready`, for a failed access.

## Operation
- States: IDLE, WAIT, XFER, XFER2, DONE.
- IDLE: an `ale` with `rd` xor `wr` latches addr/op/word/wdata and moves to WAIT. If `WAIT_STATES`=0, it moves directly to XFER. An `ale` with neither `rd` nor `wr` is ignored.
- `rd`&`wr` both high at `ale`: the access is flagged as an error.
- `ale` in any state other than IDLE is ignored, with no side effects.
- WAIT: counts `WAIT_STATES` cycles, then moves to XFER.
- XFER handles the low byte, or the whole word when the address is even:
  - Byte access: operates on the byte at `addr`.
  - Even word access: operates on bytes `addr` and `addr+1` in a single cycle.
  - Odd word access: operates on the low byte at `addr`, then goes to XFER2.
- XFER2: operates on the byte at `addr+1` (the next word's low byte).
- DONE: drives `ready`=1 and returns to IDLE.
- Address arithmetic is 20-bit modulo: `addr+1` at 20'hFFFFF wraps to 20'h00000.
- Read data placement:
  - Byte read: rdata = {8'h00, byte}.
  - Word read: rdata = {byte@addr+1, byte@addr}.
- Error: any target byte outside the window, or `rd`&`wr` both high.
  - No memory byte is written.
  - Latency is unchanged.
  - `err`=1 with `ready`.
  - On a read, rdata = 16'hFFFF.
  - The window check covers both bytes before XFER, so a split word with its high byte outside the window writes nothing.
- Memory array contents are not reset.

## Timing
- Reset values: `rdata`=16'h0000, `ready`=0, `busy`=0, `err`=0, state IDLE, wait counter 0.
- Take the `ale`-sampling edge as edge 0.
- `ready` rises at edge `WAIT_STATES`+2 for byte and aligned word accesses.
- `ready` rises at edge `WAIT_STATES`+3 for a split word access.
- The next `ale` is accepted in the cycle after `ready`; back-to-back accesses are possible.
- Reads sample memory in XFER/XFER2. Writes commit at the end of XFER (low byte) and XFER2 (high byte).
- Reset mid-operation aborts immediately with no `ready`. Bytes already committed remain; for a split write reset during XFER2, only the low byte is written.

## Configuration
- `MEM_RESP_UNALIGNED_EN` defined: odd-address word accesses are split over XFER/XFER2 as described above.
- Not defined: XFER2 does not exist. An odd-address word access is an error (`err`=1, no write, rdata=16'hFFFF) with aligned latency `WAIT_STATES`+2.

## Test plan
- Reset, then write word 16'hBEEF to 20'h00010 and read it back, with `WAIT_STATES`=1 → `ready` at edge 3 both times, rdata=16'hBEEF, `err`=0.
- Byte write 8'h5A to 20'h00011, then word read at 20'h00010 → rdata=16'h5AEF.
- Macro on: word write 16'h1234 to 20'h00021, then byte reads at 20'h00021 and 20'h00022 → 16'h0034 and 16'h0012; the write's `ready` comes at edge 4. Macro off: the same write → `err`=1, memory unchanged.
- `MEM_BASE`=20'hFFC00, `MEM_WORDS`=512: read at 20'h003FF → `err`, rdata=16'hFFFF. Word read at 20'hFFFFF → `err`, because the wrapped byte 20'h00000 is outside the window.
- Second `ale` pulsed during WAIT → ignored, single `ready`. `rd`&`wr` both high → `err`, no write. `rst` asserted during XFER2 of a split write → outputs zero immediately, only the low byte is written.
